// File: rtl/lutram_sdp_clr.sv
// Simple-dual-port distributed RAM with per-bit write mask, 1- or 2-cycle registered read,
// selectable read-during-write policy and a hardware clear sweep after reset or on request.
module lutram_sdp_clr #(
  parameter int unsigned      WIDTH        = 32'd8,
  parameter int unsigned      DEPTH        = 32'd16,
  parameter int unsigned      DEPTH_BITS   = 32'd4,
  parameter int unsigned      READ_LATENCY = 32'd1,
  parameter int unsigned      RDW_MODE     = 32'd0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE  = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [DEPTH_BITS-1:0] write_address,
  input  logic [WIDTH-1:0]      write_data_in,
  input  logic [WIDTH-1:0]      write_mask,
  input  logic                  read_en,
  input  logic [DEPTH_BITS-1:0] read_address,
  output logic [WIDTH-1:0]      read_data_out,
  output logic                  read_valid,
  input  logic                  clear_req,
  output logic                  busy
);

  localparam logic [DEPTH_BITS-1:0] LAST_ADDR = DEPTH_BITS'(DEPTH - 32'd1);
  localparam logic [DEPTH_BITS:0]   DEPTH_L   = (DEPTH_BITS + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  logic [WIDTH-1:0]      mem_r [DEPTH];
  state_t                state_r, state_next_s;
  logic [DEPTH_BITS-1:0] clr_cnt_r, clr_cnt_next_s;
  logic                  busy_r;

  logic                  port_open_s;
  logic                  wr_in_range_s, rd_in_range_s;
  logic                  wr_fire_s, rd_fire_s;
  logic [WIDTH-1:0]      wr_old_s, wr_merged_s, rd_word_s;

  logic                  out_valid_s;
  logic [WIDTH-1:0]      out_data_s;
  logic                  read_valid_r;
  logic [WIDTH-1:0]      read_data_r;

  // Request qualification, masked merge and read-word selection.
  always_comb begin
    wr_in_range_s = ({1'b0, write_address} < DEPTH_L);
    rd_in_range_s = ({1'b0, read_address} < DEPTH_L);
    wr_old_s      = mem_r[write_address];
    wr_merged_s   = (wr_old_s & ~write_mask) | (write_data_in & write_mask);
    // A clear request in IDLE wins over any access presented in the same cycle.
    port_open_s   = (state_r == ST_IDLE) && !clear_req;
    wr_fire_s     = port_open_s && write_en && wr_in_range_s;
    rd_fire_s     = port_open_s && read_en;
    if (!rd_in_range_s) begin
      rd_word_s = CLEAR_VALUE;
    end else if ((RDW_MODE == 32'd1) && wr_fire_s && (write_address == read_address)) begin
      rd_word_s = wr_merged_s;
    end else begin
      rd_word_s = mem_r[read_address];
    end
  end

  // Clear sequencer next-state logic.
  always_comb begin
    state_next_s   = state_r;
    clr_cnt_next_s = clr_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_req) begin
          state_next_s   = ST_CLEAR;
          clr_cnt_next_s = {DEPTH_BITS{1'b0}};
        end else begin
          state_next_s   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_next_s   = ST_IDLE;
          clr_cnt_next_s = {DEPTH_BITS{1'b0}};
        end else begin
          clr_cnt_next_s = clr_cnt_r + {{(DEPTH_BITS-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next_s   = ST_CLEAR;
        clr_cnt_next_s = {DEPTH_BITS{1'b0}};
      end
    endcase
  end

  // Clear sequencer state register; reset restarts the sweep from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= {DEPTH_BITS{1'b0}};
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      clr_cnt_r <= clr_cnt_next_s;
      busy_r    <= (state_next_s == ST_CLEAR);
    end
  end

  // Storage array: the sweep owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= CLEAR_VALUE;
    end else if (wr_fire_s) begin
      mem_r[write_address] <= wr_merged_s;
    end
  end

  generate
    if (READ_LATENCY == 32'd2) begin : g_lat2
      logic             s1_valid_r;
      logic [WIDTH-1:0] s1_data_r;

      // Extra pipeline stage between array read and output register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid_r <= 1'b0;
          s1_data_r  <= {WIDTH{1'b0}};
        end else begin
          s1_valid_r <= rd_fire_s;
          if (rd_fire_s) begin
            s1_data_r <= rd_word_s;
          end
        end
      end

      assign out_valid_s = s1_valid_r;
      assign out_data_s  = s1_data_r;
    end else begin : g_lat1
      assign out_valid_s = rd_fire_s;
      assign out_data_s  = rd_word_s;
    end
  endgenerate

  // Output register; data holds when no read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_valid_r <= 1'b0;
      read_data_r  <= {WIDTH{1'b0}};
    end else begin
      read_valid_r <= out_valid_s;
      if (out_valid_s) begin
        read_data_r <= out_data_s;
      end
    end
  end

  assign read_valid    = read_valid_r;
  assign read_data_out = read_data_r;
  assign busy          = busy_r;

endmodule
